rocketcpu_codec_spi_target: RTL and testbench

- 3-wire SPI target (responder) for the codec control bus: the receive end of the CS/CLK/DI link driven by the codec SPI master.
- Captures 16-bit frames MSB-first: 7-bit register address plus 9-bit data.
- Commits each complete frame into a shadow register file.
- Shadow file and a status word are read back over the Wishbone slave port. Used as a codec model in simulation and as a readback mirror of codec configuration in the SoC.

---
 rtl/rocketcpu_codec_pkg.sv | 17 +
 rtl/rocketcpu_sync_edge.sv | 30 +++
 rtl/rocketcpu_codec_spi_target.sv | 161 ++++++++++++++++
 tb/tb_rocketcpu_codec_spi_target.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rocketcpu_codec_pkg.sv
// rtl/rocketcpu_codec_pkg.sv - shared constants and FSM state type for the codec SPI target
package rocketcpu_codec_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int ADDR_BITS      = 7;
  localparam int DATA_BITS      = 9;
  localparam int STATUS_ERR_BIT = 15;

  localparam logic [ADDR_BITS-1:0] CODEC_RESET_ADDR = 7'h0F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/rocketcpu_sync_edge.sv
// rtl/rocketcpu_sync_edge.sv - multi-flop input synchronizer with rise/fall pulse outputs
module rocketcpu_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/rocketcpu_codec_spi_target.sv
// rtl/rocketcpu_codec_spi_target.sv - 3-wire codec SPI target with Wishbone shadow readback
// Optional: ROCKETCPU_CODEC_SPI_TARGET_SWRESET_EN makes a frame to 0x0F clear the shadow file.
module rocketcpu_codec_spi_target
  import rocketcpu_codec_pkg::*;
#(
  parameter int NREGS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic [4:0]  i_wb_adr,
  input  logic [15:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic        o_wb_ack,
  output logic [15:0] o_wb_dat,
  input  logic        codec_clk,
  input  logic        codec_cs,
  input  logic        codec_di,
  output logic        o_frame_done
);

  localparam int         IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [7:0] NREGS_W = 8'(NREGS);

  logic sclk_rise, sclk_fall_unused, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic di_level, di_rise_unused, di_fall_unused;

  rocketcpu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(i_wb_clk), .rst_n(i_wb_rst_n), .din(codec_clk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  rocketcpu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(i_wb_clk), .rst_n(i_wb_rst_n), .din(codec_cs),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  rocketcpu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_di (
    .clk(i_wb_clk), .rst_n(i_wb_rst_n), .din(codec_di),
    .level(di_level), .rise(di_rise_unused), .fall(di_fall_unused)
  );

  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [4:0]             count_q;
  logic [7:0]             frame_cnt_q;
  logic                   err_q;
  logic                   pend_q;
  logic                   done_q;
  logic [DATA_BITS-1:0]   regs_q [NREGS];

  logic [ADDR_BITS-1:0]   frame_addr;
  logic [DATA_BITS-1:0]   frame_data;
  logic                   addr_in_range;
  logic                   frame_ok;
  logic                   commit;
  logic                   wb_take;
  logic                   wb_status;
  logic [15:0]            rd_data;
  logic [14:0]            wb_dat_unused;

  assign frame_addr    = shift_q[FRAME_BITS-1 -: ADDR_BITS];
  assign frame_data    = shift_q[DATA_BITS-1:0];
  assign addr_in_range = {1'b0, frame_addr} < NREGS_W;
  assign commit        = (state_q == COMMIT);
  assign wb_take       = i_wb_cyc & ~o_wb_ack & ~done_q;
  assign wb_status     = ({3'b0, i_wb_adr} == NREGS_W);
  assign wb_dat_unused = i_wb_dat[14:0];

`ifdef ROCKETCPU_CODEC_SPI_TARGET_SWRESET_EN
  logic is_swreset;
  assign is_swreset = (frame_addr == CODEC_RESET_ADDR);
  assign frame_ok   = (count_q == 5'(FRAME_BITS)) & (addr_in_range | is_swreset);
`else
  assign frame_ok   = (count_q == 5'(FRAME_BITS)) & addr_in_range;
`endif

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall || pend_q) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A CS fall seen during COMMIT is remembered so the next frame starts from IDLE.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      shift_q <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      pend_q <= commit & cs_fall;
      if (state_q == IDLE && (cs_fall || pend_q)) begin
        shift_q <= '0;
        count_q <= '0;
      end else if (state_q == SHIFT && sclk_rise && !cs_rise) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], di_level};
        if (count_q != 5'd31) count_q <= count_q + 5'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ({3'b0, i_wb_adr} < NREGS_W) begin
      rd_data[DATA_BITS-1:0] = regs_q[i_wb_adr[IDX_W-1:0]];
    end else if (wb_status) begin
      rd_data[7:0]            = frame_cnt_q;
      rd_data[STATUS_ERR_BIT] = err_q;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
      o_frame_done <= 1'b0;
      o_wb_ack     <= 1'b0;
      o_wb_dat     <= '0;
      done_q       <= 1'b0;
    end else begin
      o_frame_done <= commit & frame_ok;
      o_wb_ack     <= wb_take;
      done_q       <= i_wb_cyc & (done_q | o_wb_ack);

      if (wb_take) begin
        o_wb_dat <= rd_data;
        if (i_wb_we && wb_status && i_wb_dat[STATUS_ERR_BIT]) err_q <= 1'b0;
      end

      if (commit) begin
        if (frame_ok) begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
`ifdef ROCKETCPU_CODEC_SPI_TARGET_SWRESET_EN
          if (is_swreset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
          end else begin
            regs_q[frame_addr[IDX_W-1:0]] <= frame_data;
          end
`else
          regs_q[frame_addr[IDX_W-1:0]] <= frame_data;
`endif
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rocketcpu_codec_spi_target.sv
// tb/tb_rocketcpu_codec_spi_target.sv - directed bench for the codec SPI target
module tb_rocketcpu_codec_spi_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  adr;
  logic [15:0] wdat;
  logic        we, cyc;
  logic        ack;
  logic [15:0] rdat;
  logic        sclk, cs, di;
  logic        done;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;
  logic [15:0] rd;

  always #5 clk = ~clk;

  rocketcpu_codec_spi_target #(.NREGS(16), .SYNC_STAGES(2)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(wdat),
    .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_ack(ack), .o_wb_dat(rdat),
    .codec_clk(sclk), .codec_cs(cs), .codec_di(di), .o_frame_done(done)
  );

  always @(posedge clk) if (done === 1'b1) pulses++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [31:0] w, input int n);
    cs = 1'b0;
    tick(2);
    for (int i = n - 1; i >= 0; i--) begin
      di = w[i];
      tick(1);
      sclk = 1'b1;
      tick(1);
      sclk = 1'b0;
    end
    tick(1);
    cs = 1'b1;
  endtask

  task automatic frame(input logic [15:0] w);
    spi_bits({16'h0, w}, 16);
    tick(8);
  endtask

  task automatic wb_xfer(input logic [4:0] a, input logic [15:0] v, input logic w,
                         input bit hold, output logic [15:0] d);
    bit got_ack;
    got_ack = 1'b0;
    d = 16'hDEAD;
    adr = a; wdat = v; we = w; cyc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        got_ack = 1'b1;
        d = rdat;
        break;
      end
    end
    check("wb_ack_seen", {15'h0, got_ack}, 16'h0001);
    if (hold) begin
      @(negedge clk);
      check("ack_single_1", {15'h0, ack}, 16'h0000);
      @(negedge clk);
      check("ack_single_2", {15'h0, ack}, 16'h0000);
    end
    @(posedge clk); #1;
    cyc = 1'b0; we = 1'b0;
    tick(1);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [15:0] exp);
    logic [15:0] d;
    wb_xfer(a, 16'h0, 1'b0, 1'b0, d);
    check(tag, d, exp);
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [15:0] v);
    logic [15:0] d;
    wb_xfer(a, v, 1'b1, 1'b0, d);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; di = 1'b0;
    adr = '0; wdat = '0; we = 1'b0; cyc = 1'b0;
    tick(3);
    check("rst_ack", {15'h0, ack}, 16'h0000);
    check("rst_dat", rdat, 16'h0000);
    check("rst_done", {15'h0, done}, 16'h0000);
    rst_n = 1'b1;
    tick(4);
    rd_check("rst_status", 5'd16, 16'h0000);
    rd_check("rst_reg9", 5'd9, 16'h0000);

    frame(16'h1297);
    check("f1_pulses", 16'(pulses), 16'd1);
    rd_check("f1_reg9", 5'd9, 16'h0097);
    rd_check("f1_status", 5'd16, 16'h0001);

    spi_bits(32'h0000_052A, 15);
    tick(8);
    spi_bits(32'h0001_4AAA, 17);
    tick(8);
    check("badlen_pulses", 16'(pulses), 16'd1);
    rd_check("badlen_status", 5'd16, 16'h8001);
    rd_check("badlen_reg5", 5'd5, 16'h0000);
    wb_write(5'd16, 16'h8000);
    rd_check("errclr_status", 5'd16, 16'h0001);

    cs = 1'b0; tick(3); cs = 1'b1; tick(8);
    rd_check("zerobit_status", 5'd16, 16'h8001);
    wb_write(5'd16, 16'h8000);

    frame(16'h29FF);
    rd_check("badaddr_status", 5'd16, 16'h8001);
    rd_check("badaddr_reg4", 5'd4, 16'h0000);
    rd_check("badaddr_reg9", 5'd9, 16'h0097);
    wb_write(5'd16, 16'h8000);

    spi_bits(32'h0000_0A55, 16);
    tick(1);
    spi_bits(32'h0000_0C3C, 16);
    tick(8);
    check("b2b_pulses", 16'(pulses), 16'd3);
    rd_check("b2b_reg5", 5'd5, 16'h0055);
    rd_check("b2b_reg6", 5'd6, 16'h003C);
    rd_check("b2b_status", 5'd16, 16'h0003);

    wb_xfer(5'd20, 16'h0, 1'b0, 1'b1, rd);
    check("above_rd", rd, 16'h0000);
    wb_write(5'd6, 16'h01FF);
    rd_check("regwr_ignored", 5'd6, 16'h003C);
    wb_write(5'd16, 16'h7FFF);
    rd_check("statwr_ignored", 5'd16, 16'h0003);

    cs = 1'b0;
    tick(2);
    for (int i = 15; i >= 8; i--) begin
      di = (i % 2 == 0);
      tick(1); sclk = 1'b1; tick(1); sclk = 1'b0;
    end
    rst_n = 1'b0; cs = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    frame(16'h10AA);
    check("abort_pulses", 16'(pulses), 16'd4);
    rd_check("abort_reg8", 5'd8, 16'h00AA);
    rd_check("abort_reg5", 5'd5, 16'h0000);
    rd_check("abort_reg9", 5'd9, 16'h0000);
    rd_check("abort_status", 5'd16, 16'h0001);

    frame(16'h0201);
    frame(16'h0402);
    frame(16'h0603);
    rd_check("load_reg2", 5'd2, 16'h0002);
    frame(16'h1E05);
    check("swr_pulses", 16'(pulses), 16'd8);
    rd_check("swr_status", 5'd16, 16'h0005);
`ifdef ROCKETCPU_CODEC_SPI_TARGET_SWRESET_EN
    rd_check("swr_reg1", 5'd1, 16'h0000);
    rd_check("swr_reg3", 5'd3, 16'h0000);
    rd_check("swr_reg8", 5'd8, 16'h0000);
    rd_check("swr_reg15", 5'd15, 16'h0000);
`else
    rd_check("swr_reg1", 5'd1, 16'h0001);
    rd_check("swr_reg3", 5'd3, 16'h0003);
    rd_check("swr_reg8", 5'd8, 16'h00AA);
    rd_check("swr_reg15", 5'd15, 16'h0005);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
